// File: rtl/freq_div_prog_if.sv
// Control/status bundle for freq_div_prog: enable, divisor load request and
// the divided-clock, tick and load-status outputs.
interface freq_div_prog_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             div_out;
    logic             tick;
    logic             div_ack;
    logic             div_err;
    logic [CNT_W-1:0] div_cur;

    modport master (
        output en, div_in, div_load,
        input  div_out, tick, div_ack, div_err, div_cur
    );

    modport slave (
        input  en, div_in, div_load,
        output div_out, tick, div_ack, div_err, div_cur
    );
endinterface

// File: rtl/freq_div_prog.sv
// Runtime-programmable integer clock divider (N = 2..2^CNT_W-1) with period tick.
// Define FREQ_DIV_ODD_DUTY_EN for exact 50% duty on odd N via a falling-edge flop.
module freq_div_prog #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DIV_RST = 6
) (
    input logic            clk,
    input logic            rst,
    freq_div_prog_if.slave bus
);
    localparam logic [CNT_W-1:0] CntRst = CNT_W'(DIV_RST - 1);
    localparam logic [CNT_W-1:0] DivRst = CNT_W'(DIV_RST);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] div_nxt, hi;
    logic             pend_v_q, pend_v_d;
    logic             div_out_q, div_out_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             wrap, load_ok;

    always_comb begin
        load_ok   = bus.div_load && (bus.div_in > CNT_W'(1));
        wrap      = (cnt_q == div_cur_q - CNT_W'(1));
        cnt_d     = cnt_q;
        div_cur_d = div_cur_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        div_out_d = div_out_q;
        tick_d    = 1'b0;
        ack_d     = 1'b0;
        err_d     = bus.div_load && !load_ok;
        div_nxt   = div_cur_q;

        if (load_ok) begin
            pend_d   = bus.div_in;
            pend_v_d = 1'b1;
        end

        if (bus.en) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                // A same-cycle load beats an older pending one.
                if (load_ok) begin
                    div_nxt = bus.div_in;
                    ack_d   = 1'b1;
                end else if (pend_v_q) begin
                    div_nxt = pend_q;
                    ack_d   = 1'b1;
                end
                pend_v_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            div_cur_d = div_nxt;
        end

`ifdef FREQ_DIV_ODD_DUTY_EN
        hi = div_nxt >> 1;
`else
        hi = (div_nxt >> 1) + {{(CNT_W - 1){1'b0}}, div_nxt[0]};
`endif

        if (bus.en) begin
            div_out_d = (cnt_d < hi);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= CntRst;
            div_cur_q <= DivRst;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_cur_q <= div_cur_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

`ifdef FREQ_DIV_ODD_DUTY_EN
    // Half-cycle delayed copy stretches odd-N high time by half a clock.
    logic neg_q;

    always_ff @(negedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= div_out_q;
        end
    end

    assign bus.div_out = div_out_q | neg_q;
`else
    assign bus.div_out = div_out_q;
`endif

    assign bus.tick    = tick_q;
    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;
    assign bus.div_cur = div_cur_q;
endmodule

// File: tb/tb_freq_div_prog.sv
// Directed, table-driven bench for freq_div_prog (default build, DIV_RST=6).
module tb_freq_div_prog;
    logic clk;
    logic rst;

    freq_div_prog_if #(.CNT_W(8)) bus ();

    freq_div_prog #(
        .CNT_W  (8),
        .DIV_RST(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] din;
        logic       ld;
        logic       out;
        logic       tick;
        logic       ack;
        logic       err;
        logic [7:0] cur;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic add(input logic r, input logic e, input int din, input logic ld,
                       input logic o, input logic t, input logic a, input logic er,
                       input int cur);
        vec_t v;
        v.rst  = r;
        v.en   = e;
        v.din  = 8'(din);
        v.ld   = ld;
        v.out  = o;
        v.tick = t;
        v.ack  = a;
        v.err  = er;
        v.cur  = 8'(cur);
        vecs.push_back(v);
    endtask

    // n enabled cycles with no load; patterns read MSB (first cycle) to LSB.
    task automatic run(input int n, input logic [31:0] outs, input logic [31:0] ticks,
                       input int cur);
        for (int i = n - 1; i >= 0; i--) begin
            add(1'b0, 1'b1, 0, 1'b0, outs[i], ticks[i], 1'b0, 1'b0, cur);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int gap;
        int highs;
        logic [11:0] got;
        logic [11:0] exp;

        n_vec = 0;
        n_bad = 0;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.div_in   = '0;
        bus.div_load = 1'b0;

        // Reset state
        add(1, 0, 0, 0, 0, 0, 0, 0, 6);
        // Three N=6 periods from reset
        run(18, 18'b111000111000111000, 18'b100000100000100000, 6);
        // Load 5 at cnt=2; the 6-period completes, then 11100 repeats
        run(3, 3'b111, 3'b100, 6);
        add(0, 1, 5, 1, 0, 0, 0, 0, 6);
        run(2, 2'b00, 2'b00, 6);
        add(0, 1, 0, 0, 1, 1, 1, 0, 5);
        run(9, 9'b110011100, 9'b000010000, 5);
        // Same-cycle load at the wrap goes straight in
        add(0, 1, 6, 1, 1, 1, 1, 0, 6);
        // Illegal loads 1 and 0: err each, no ack, divisor unchanged
        add(0, 1, 1, 1, 1, 0, 0, 1, 6);
        add(0, 1, 0, 1, 1, 0, 0, 1, 6);
        add(0, 1, 0, 0, 0, 0, 0, 0, 6);
        run(2, 2'b00, 2'b00, 6);
        run(1, 1'b1, 1'b1, 6);
        // Load 4 then 10 in one period: only 10 lands, one ack
        add(0, 1, 4, 1, 1, 0, 0, 0, 6);
        add(0, 1, 10, 1, 1, 0, 0, 0, 6);
        run(3, 3'b000, 3'b000, 6);
        add(0, 1, 0, 0, 1, 1, 1, 0, 10);
        run(10, 10'b1111000001, 10'b0000000001, 10);
        // Freeze 7 cycles mid-high phase, with a load of 2 made while frozen
        run(1, 1'b1, 1'b0, 10);
        for (int i = 0; i < 7; i++) begin
            add(0, 0, (i == 3) ? 2 : 0, (i == 3), 1, 0, 0, 0, 10);
        end
        run(8, 8'b11100000, 8'b00000000, 10);
        add(0, 1, 0, 0, 1, 1, 1, 0, 2);
        // N=2: toggles every cycle
        run(4, 4'b0101, 4'b0101, 2);
        // Reset mid-period with a pending load of 7: load discarded
        add(0, 1, 7, 1, 0, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 0, 0, 0, 6);
        run(12, 12'b111000111000, 12'b100000100000, 6);
        // Switch to the largest divisor at the wrap
        add(0, 1, 255, 1, 1, 1, 1, 0, 255);

        for (int i = 0; i < vecs.size(); i++) begin
            rst          = vecs[i].rst;
            bus.en       = vecs[i].en;
            bus.div_in   = vecs[i].din;
            bus.div_load = vecs[i].ld;
            @(posedge clk);
            #1;
            got = {bus.div_out, bus.tick, bus.div_ack, bus.div_err, bus.div_cur};
            exp = {vecs[i].out, vecs[i].tick, vecs[i].ack, vecs[i].err, vecs[i].cur};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL vec%0d: got out/tick/ack/err/cur=%b%b%b%b/%0d, expected %b%b%b%b/%0d",
                         i, got[11], got[10], got[9], got[8], got[7:0],
                         exp[11], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end

        // N=255: one full period, bounded wait for the next tick
        rst          = 1'b0;
        bus.en       = 1'b1;
        bus.div_load = 1'b0;
        bus.div_in   = '0;
        gap   = 0;
        highs = 1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (bus.tick) begin
                gap = c;
                break;
            end
            highs += int'(bus.div_out);
        end
        check_int("n255_period", gap, 255);
        check_int("n255_high_cycles", highs, 128);
        check_int("n255_cur", int'(bus.div_cur), 255);
        check_int("n255_no_ack", int'(bus.div_ack), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
